// File: rtl/fb_pkg.sv
// Framebuffer geometry and memory map shared by the display reader and the
// pixel writer, so both sides compute SRAM addresses the same way.
package fb_pkg;

  localparam int unsigned H_PIXELS       = 640;
  localparam int unsigned V_LINES        = 480;
  localparam int unsigned BYTES_PER_LINE = H_PIXELS / 8;
  localparam int unsigned FB_WORDS       = BYTES_PER_LINE * V_LINES;
  localparam int unsigned ADDR_W         = 18;
  localparam int unsigned IDX_W          = 7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA_WAIT
  } rd_state_t;

  // Word address of the first byte of line y: y*80 as y*64 + y*16.
  function automatic logic [ADDR_W-1:0] line_base(input logic [9:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext = {8'd0, y};
    return (y_ext << 6) + (y_ext << 4);
  endfunction

endpackage

// File: rtl/read_buffer_if.sv
// SRAM controller handshake shared with the pixel writer through the arbiter.
interface read_buffer_if;
  import fb_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              ram_read;
  logic              ram_ready;
  logic [15:0]       data_read;

  modport master (
    output address,
    output ram_read,
    input  ram_ready,
    input  data_read
  );

  modport slave (
    input  address,
    input  ram_read,
    output ram_ready,
    output data_read
  );

endinterface

// File: rtl/line_buffer.sv
// Two-bank line store: one bank is filled from SRAM while the other is shown.
module line_buffer
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic             wr_bank,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_data,
  input  logic             rd_bank,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_data
);

  logic [7:0] mem [2][BYTES_PER_LINE];

  // Synchronous write into the fill bank; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_bank][wr_idx] <= wr_data;
  end

  // Asynchronous read of the display bank; bytes past the line read as blank.
  always_comb begin
    rd_data = '0;
    if (rd_idx < 7'(BYTES_PER_LINE)) rd_data = mem[rd_bank][rd_idx];
  end

endmodule

// File: rtl/read_buffer.sv
// Display-side framebuffer reader: prefetches the next 80-byte line from SRAM
// into the fill bank while the display bank feeds the registered pixel output.
module read_buffer
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 new_line,
  input  logic [9:0]           next_y,
  input  logic [9:0]           hcount,
  input  logic                 visible,
  read_buffer_if.master        ram,
  output logic                 pixel,
  output logic                 fetch_busy,
  output logic                 underrun
);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  index;
  logic              disp_bank;

  logic              y_valid;
  logic              accepted;
  logic              last_byte;
  logic              ram_read_d;
  logic              addr_ld;
  logic              byte_wr;
  logic [7:0]        rd_data;
  logic              pix_d;
  logic              unused_data_hi;

  assign y_valid        = next_y < 10'(V_LINES);
  // Only our own outstanding request counts as accepted when ready drops.
  assign accepted       = ram.ram_read && !ram.ram_ready;
  assign last_byte      = index == 7'(BYTES_PER_LINE - 1);
  assign unused_data_hi = ^ram.data_read[15:8];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end

  // Next-state logic; new_line always wins and restarts the fetch.
  always_comb begin
    state_nxt = state;
    if (new_line) begin
      state_nxt = y_valid ? REQ : IDLE;
    end else begin
      case (state)
        REQ:       if (accepted) state_nxt = DATA_WAIT;
        DATA_WAIT: if (ram.ram_ready) state_nxt = last_byte ? IDLE : REQ;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Output decode; the request drops on the same edge it is accepted so the
  // controller cannot mistake it for a second access.
  always_comb begin
    ram_read_d = 1'b0;
    addr_ld    = 1'b0;
    byte_wr    = 1'b0;
    if (!new_line) begin
      case (state)
        REQ: begin
          addr_ld    = 1'b1;
          ram_read_d = !accepted;
        end
        DATA_WAIT: byte_wr = ram.ram_ready;
        default: ;
      endcase
    end
  end

  // Fetch datapath, bank select and handshake registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram.address  <= '0;
      ram.ram_read <= 1'b0;
      base         <= '0;
      index        <= '0;
      disp_bank    <= 1'b0;
      fetch_busy   <= 1'b0;
      underrun     <= 1'b0;
    end else if (clk_en) begin
      ram.ram_read <= ram_read_d;
      if (addr_ld) ram.address <= base + {{(ADDR_W-IDX_W){1'b0}}, index};
      if (new_line) begin
        disp_bank  <= ~disp_bank;
        base       <= line_base(next_y);
        index      <= '0;
        fetch_busy <= y_valid;
        if (fetch_busy) underrun <= 1'b1;
      end else if (byte_wr) begin
        if (last_byte) fetch_busy <= 1'b0;
        else           index      <= index + 1'b1;
      end
    end
  end

  line_buffer u_line_buffer (
    .clk     (clk),
    .we      (clk_en && byte_wr),
    .wr_bank (~disp_bank),
    .wr_idx  (index),
    .wr_data (ram.data_read[7:0]),
    .rd_bank (disp_bank),
    .rd_idx  (hcount[9:3]),
    .rd_data (rd_data)
  );

  // Pixel select: bit 0 of each byte is the leftmost pixel.
  always_comb begin
    pix_d = 1'b0;
    if (visible && hcount < 10'(H_PIXELS)) pix_d = rd_data[hcount[2:0]];
  end

  // Registered pixel output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pixel <= 1'b0;
    else if (clk_en) pixel <= pix_d;
  end

endmodule

// File: tb/tb_read_buffer.sv
// Self-checking bench for read_buffer: SRAM controller model with adjustable
// latency, request monitor, and a line-level pixel reference model.
module tb_read_buffer;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b1;
  logic       new_line = 1'b0;
  logic [9:0] next_y = '0;
  logic [9:0] hcount = '0;
  logic       visible = 1'b0;
  logic       pixel;
  logic       fetch_busy;
  logic       underrun;

  read_buffer_if bus ();

  read_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .new_line   (new_line),
    .next_y     (next_y),
    .hcount     (hcount),
    .visible    (visible),
    .ram        (bus),
    .pixel      (pixel),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  logic [7:0]  sram [0:FB_WORDS-1];
  int          lat = 1;
  int          vectors = 0;
  int          errors = 0;
  logic [17:0] req_log [$];
  int          addr_moves = 0;

  // SRAM controller model: ready drops when a request is taken, returns with
  // data after lat negedges; the upper data byte is garbage.
  initial begin : ctrl
    int          cnt;
    logic        busy;
    logic [17:0] a;
    cnt = 0; busy = 1'b0; a = '0;
    bus.ram_ready = 1'b1;
    bus.data_read = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy = 1'b0;
        bus.ram_ready = 1'b1;
      end else if (busy) begin
        cnt--;
        if (cnt <= 0) begin
          busy = 1'b0;
          bus.ram_ready = 1'b1;
          bus.data_read = {8'($urandom), (a < 18'(FB_WORDS)) ? sram[a] : 8'h00};
        end
      end else if (bus.ram_read) begin
        busy = 1'b1;
        cnt = lat;
        a = bus.address;
        bus.ram_ready = 1'b0;
        bus.data_read = 16'($urandom);
      end
    end
  end

  // Request monitor: logs each new request address, counts address changes
  // while a request is held.
  initial begin : mon
    logic        prev_rr;
    logic [17:0] prev_a;
    prev_rr = 1'b0; prev_a = '0;
    forever begin
      @(negedge clk);
      if (bus.ram_read && !prev_rr) req_log.push_back(bus.address);
      if (bus.ram_read && prev_rr && bus.address !== prev_a) addr_moves++;
      prev_rr = bus.ram_read;
      prev_a  = bus.address;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference: what a fully fetched line y must show at hc.
  function automatic logic model_pixel(input int y, input int hc, input logic vis);
    logic [7:0] b;
    if (!vis || hc >= int'(H_PIXELS)) return 1'b0;
    b = sram[y * int'(BYTES_PER_LINE) + hc / 8];
    return b[hc % 8];
  endfunction

  task automatic pulse_new_line(input int y);
    next_y = 10'(y);
    new_line = 1'b1;
    @(negedge clk);
    new_line = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int used, output bit timeout);
    used = 0;
    while (fetch_busy && used < budget) begin
      @(negedge clk);
      used++;
    end
    timeout = fetch_busy;
  endtask

  task automatic wait_reqs(input int n, input int budget, output bit timeout);
    int c;
    c = 0;
    while (req_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    timeout = (req_log.size() < n);
  endtask

  task automatic sweep_line(input int y, input string tag);
    logic exp_pix;
    int   hc;
    for (int i = 0; i < 820; i++) begin
      hc = (i < 800) ? i : int'($urandom_range(800, 1023));
      hcount  = 10'(hc);
      visible = ($urandom_range(0, 7) != 0);
      exp_pix = model_pixel(y, hc, visible);
      @(negedge clk);
      vectors++;
      if (pixel !== exp_pix) begin
        errors++;
        $display("FAIL %s hcount=%0d visible=%b pixel=%b expected=%b", tag, hc, visible, pixel, exp_pix);
      end
    end
    visible = 1'b0;
    hcount  = '0;
  endtask

  task automatic test_reset();
    bit to;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.address, bus.ram_read, pixel, fetch_busy, underrun} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state addr=%0d rr=%b pix=%b busy=%b ur=%b expected all 0",
               bus.address, bus.ram_read, pixel, fetch_busy, underrun);
    end
    reset = 1'b1;
    @(negedge clk);
    pulse_new_line(3);
    req_log.delete();
    wait_reqs(3, 40, to);
    vectors++;
    if (to !== 1'b0) begin errors++; $display("FAIL reset_fetch_start timeout=%b expected 0", to); end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({bus.address, bus.ram_read, pixel, fetch_busy, underrun} !== 22'd0) begin
      errors++;
      $display("FAIL reset_async addr=%0d rr=%b pix=%b busy=%b ur=%b expected all 0",
               bus.address, bus.ram_read, pixel, fetch_busy, underrun);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_log.delete();
    repeat (10) @(negedge clk);
    vectors++;
    if (req_log.size() !== 0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle requests=%0d busy=%b expected 0 and 0", req_log.size(), fetch_busy);
    end
  endtask

  task automatic test_single_line();
    bit to;
    int used;
    for (int k = 0; k < int'(BYTES_PER_LINE); k++) sram[5 * 80 + k] = 8'(k);
    lat = 1;
    addr_moves = 0;
    pulse_new_line(5);
    req_log.delete();
    wait_idle(800, used, to);
    vectors++;
    if (to !== 1'b0) begin errors++; $display("FAIL single_done busy_after=%0d expected done", used); end
    vectors++;
    if (req_log.size() !== 80) begin errors++; $display("FAIL single_count reqs=%0d expected 80", req_log.size()); end
    for (int k = 0; k < req_log.size() && k < 80; k++) begin
      vectors++;
      if (req_log[k] !== 18'(400 + k)) begin
        errors++;
        $display("FAIL single_addr[%0d] addr=%0d expected %0d", k, req_log[k], 400 + k);
      end
    end
    vectors++;
    if (underrun !== 1'b0 || addr_moves !== 0) begin
      errors++;
      $display("FAIL single_clean underrun=%b addr_moves=%0d expected 0 and 0", underrun, addr_moves);
    end
    pulse_new_line(6);
    sweep_line(5, "single_pixel");
    wait_idle(800, used, to);
  endtask

  task automatic test_bit_order();
    bit          to;
    int          used;
    logic [7:0]  pat [2];
    pat[0] = 8'h01;
    pat[1] = 8'h80;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < int'(BYTES_PER_LINE); k++) sram[k] = 8'h00;
      sram[0] = pat[p];
      pulse_new_line(0);
      wait_idle(800, used, to);
      vectors++;
      if (to !== 1'b0) begin errors++; $display("FAIL bitorder_done pattern=%h timeout", pat[p]); end
      pulse_new_line(480);
      sweep_line(0, (p == 0) ? "bitorder_01" : "bitorder_80");
    end
  endtask

  task automatic test_slow_controller();
    bit to;
    int used;
    int y;
    y = int'($urandom_range(1, 479));
    lat = 5;
    addr_moves = 0;
    pulse_new_line(y);
    req_log.delete();
    wait_idle(799, used, to);
    vectors++;
    if (to !== 1'b0) begin errors++; $display("FAIL slow_done cycles=%0d expected under 800", used); end
    vectors++;
    if (addr_moves !== 0) begin errors++; $display("FAIL slow_addr_stable moves=%0d expected 0", addr_moves); end
    vectors++;
    if (req_log.size() !== 80) begin errors++; $display("FAIL slow_count reqs=%0d expected 80", req_log.size()); end
    for (int k = 0; k < req_log.size() && k < 80; k++) begin
      vectors++;
      if (req_log[k] !== 18'(y * 80 + k)) begin
        errors++;
        $display("FAIL slow_addr[%0d] addr=%0d expected %0d", k, req_log[k], y * 80 + k);
      end
    end
    pulse_new_line(480);
    vectors++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL slow_underrun underrun=%b expected 0", underrun); end
    sweep_line(y, "slow_pixel");
    lat = 1;
  endtask

  task automatic test_out_of_range();
    int ys [3];
    ys[0] = 480; ys[1] = 700; ys[2] = 1023;
    for (int i = 0; i < 3; i++) begin
      pulse_new_line(ys[i]);
      req_log.delete();
      repeat (30) @(negedge clk);
      vectors++;
      if (req_log.size() !== 0 || fetch_busy !== 1'b0) begin
        errors++;
        $display("FAIL range_y%0d requests=%0d busy=%b expected 0 and 0", ys[i], req_log.size(), fetch_busy);
      end
    end
  endtask

  task automatic test_clk_en();
    bit          to;
    int          used;
    int          y;
    logic [20:0] snap;
    logic [20:0] now;
    y = int'($urandom_range(0, 479));
    lat = 2;
    addr_moves = 0;
    pulse_new_line(y);
    req_log.delete();
    repeat (15) @(negedge clk);
    clk_en = 1'b0;
    snap = {bus.address, bus.ram_read, fetch_busy, pixel};
    for (int i = 0; i < 20; i++) begin
      hcount  = 10'($urandom_range(0, 639));
      visible = 1'b1;
      @(negedge clk);
      now = {bus.address, bus.ram_read, fetch_busy, pixel};
      vectors++;
      if (now !== snap) begin
        errors++;
        $display("FAIL clken_freeze cycle=%0d state=%h expected %h", i, now, snap);
      end
    end
    clk_en = 1'b1;
    visible = 1'b0;
    wait_idle(1000, used, to);
    vectors++;
    if (to !== 1'b0 || req_log.size() !== 80) begin
      errors++;
      $display("FAIL clken_resume timeout=%b reqs=%0d expected 0 and 80", to, req_log.size());
    end
    for (int k = 0; k < req_log.size() && k < 80; k++) begin
      vectors++;
      if (req_log[k] !== 18'(y * 80 + k)) begin
        errors++;
        $display("FAIL clken_addr[%0d] addr=%0d expected %0d", k, req_log[k], y * 80 + k);
      end
    end
    pulse_new_line(480);
    sweep_line(y, "clken_pixel");
    lat = 1;
  endtask

  task automatic test_underrun();
    bit to;
    int used;
    int y1;
    int y2;
    y1 = int'($urandom_range(0, 239));
    y2 = int'($urandom_range(240, 479));
    lat = 1;
    pulse_new_line(y1);
    req_log.delete();
    wait_reqs(11, 200, to);
    vectors++;
    if (to !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_pre timeout=%b underrun=%b expected 0 and 0", to, underrun);
    end
    pulse_new_line(y2);
    req_log.delete();
    vectors++;
    if (underrun !== 1'b1 || bus.ram_read !== 1'b0) begin
      errors++;
      $display("FAIL underrun_set underrun=%b ram_read=%b expected 1 and 0", underrun, bus.ram_read);
    end
    wait_reqs(1, 20, to);
    vectors++;
    if (to !== 1'b0 || req_log[0] !== 18'(y2 * 80)) begin
      errors++;
      $display("FAIL underrun_restart timeout=%b addr=%0d expected %0d", to, (to ? 0 : req_log[0]), y2 * 80);
    end
    wait_idle(800, used, to);
    vectors++;
    if (to !== 1'b0 || req_log.size() !== 80) begin
      errors++;
      $display("FAIL underrun_refetch timeout=%b reqs=%0d expected 0 and 80", to, req_log.size());
    end
    for (int k = 0; k < req_log.size() && k < 80; k++) begin
      vectors++;
      if (req_log[k] !== 18'(y2 * 80 + k)) begin
        errors++;
        $display("FAIL underrun_addr[%0d] addr=%0d expected %0d", k, req_log[k], y2 * 80 + k);
      end
    end
    pulse_new_line(480);
    sweep_line(y2, "underrun_pixel");
    vectors++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky underrun=%b expected 1", underrun); end
  endtask

  initial begin : main
    for (int i = 0; i < int'(FB_WORDS); i++) sram[i] = 8'($urandom);
    test_reset();
    test_single_line();
    test_bit_order();
    test_slow_controller();
    test_out_of_range();
    test_clk_en();
    test_underrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/read_buffer.md
# read_buffer

Display-side framebuffer reader: prefetches one 640-pixel, 1-bpp line (80 bytes) from SRAM per video line into a double-banked line buffer and streams pixels to the VGA output. It shares the SRAM controller handshake (address / ram_read / ram_ready / data_read) with the pixel writer and uses the same memory map: byte address = (x >> 3) + y*80, pixel x in bit x[2:0] (bit 0 = leftmost). It sits between the SRAM arbiter and the VGA timing generator.

## Interface
- H_PIXELS, 640: visible pixels per line.
- V_LINES, 480: visible lines; fetch requests for y >= V_LINES are ignored.
- BYTES_PER_LINE, 80: H_PIXELS/8, SRAM words fetched per line.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clk_en  in  1  all state, including the pixel output, advances only on cycles with clk_en=1.
- new_line  in  1  one-enabled-cycle pulse from VGA timing at start of horizontal blank; swaps banks and starts fetch of next_y.
- next_y  in  10  line to prefetch, sampled with new_line.
- hcount  in  10  current display x.
- visible  in  1  display active; pixel forced 0 when low.
- address  out  18  SRAM word address.
- ram_read  out  1  read request.
- ram_ready  in  1  controller idle / data valid.
- data_read  in  16  SRAM data; only [7:0] used.
- pixel  out  1  registered pixel for hcount.
- fetch_busy  out  1  high while a line fetch is in progress.
- underrun  out  1  sticky: new_line arrived before previous fetch finished.

## Operation
- Reset values: address 0, ram_read 0, pixel 0, fetch_busy 0, underrun 0, state IDLE, display bank 0, byte index 0. Line buffer contents not reset.
- Banks: display bank read by pixel path; fill bank written by fetch. new_line toggles which is which.
- On new_line: toggle banks; latch base = next_y*80 computed as (next_y<<6)+(next_y<<4) into 18 bits; byte index := 0; if next_y < V_LINES go to REQ and fetch_busy := 1, else IDLE.
- FSM (enabled cycles only):
  - IDLE: ram_read 0; wait for new_line.
  - REQ: address := base + index; ram_read := 1; when ram_ready low (accepted) -> DATA_WAIT.
  - DATA_WAIT: ram_read := 0; when ram_ready high, write data_read[7:0] to fill[index]; if index == BYTES_PER_LINE-1 -> IDLE, fetch_busy := 0; else index+1, -> REQ.
- new_line while fetch_busy: underrun := 1 (cleared only by reset); abort current fetch (ram_read := 0 same cycle), swap, restart with new next_y. Byte left partially written is don't-care.
- Pixel path: pixel := visible ? display[hcount>>3][hcount[2:0]] : 0. hcount >= H_PIXELS reads as 0.
- reset asserted mid-fetch: ram_read drops immediately (async), FSM to IDLE; SRAM controller must tolerate a dropped request.

## Timing
- pixel latency: 1 enabled cycle after hcount/visible.
- Per byte minimum 2 enabled cycles (REQ, DATA_WAIT) plus controller wait; full line >= 160 enabled cycles; must complete within one line period (800 pixel clocks) or underrun sets.
- address valid from the cycle ram_read rises until ram_read falls; never changes while ram_read=1.
- Bank swap effective on the enabled cycle after new_line; hcount during horizontal blank so no visible tear.
- clk_en=0 freezes everything including ram_read level.

## Structure
- Shared package (fb_pkg): H_PIXELS, V_LINES, BYTES_PER_LINE, FB_WORDS=38400, address width 18, y*80 helper function; shared with the writer so memory maps cannot diverge.
- FSM state localparams: IDLE, REQ, DATA_WAIT.
- Sub-module line_buffer: 2 banks x 80 x 8 register file, one synchronous write port (fill bank), one read port (display bank), bank select input.

## Test plan
- Reset: hold reset=0 mid-fetch -> ram_read, pixel, fetch_busy, underrun all 0 immediately; address 0.
- Single line: SRAM model with byte k of line 5 = k; new_line, next_y=5 -> 80 reads at addresses 400..479, fetch_busy falls after last; next new_line then hcount=8*k+b gives bit b of k.
- Bit order: word 0x01 at address 0, line 0 displayed -> pixel=1 only at hcount=0; 0x80 -> only at hcount=7.
- Slow controller: ram_ready held low 5 cycles per access -> address stable while ram_read=1, all 80 bytes correct, no underrun if within line period.
- Underrun: new_line again after 10 bytes -> underrun=1, fetch restarts at new base, address = new_y*80.
- Out of range and clk_en: next_y=480 -> no ram_read; clk_en=0 for 20 cycles mid-fetch -> no state/output change, resumes correctly.
